// File: rtl/lb_arbiter.sv
// Two-master round-robin arbiter for the local bus; grant is held for one handshake.
// Optional grant watchdog enabled by defining LB_ARB_TIMEOUT_EN.
module lb_arbiter #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 16,
    parameter int STRB_W         = DATA_W / 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] m0_waddr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [STRB_W-1:0] m0_wstrb,
    input  logic              m0_wen,
    output logic              m0_wready,
    input  logic [ADDR_W-1:0] m0_raddr,
    input  logic              m0_ren,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_rvalid,
    input  logic [ADDR_W-1:0] m1_waddr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [STRB_W-1:0] m1_wstrb,
    input  logic              m1_wen,
    output logic              m1_wready,
    input  logic [ADDR_W-1:0] m1_raddr,
    input  logic              m1_ren,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_rvalid,
    output logic [ADDR_W-1:0] s_waddr,
    output logic [DATA_W-1:0] s_wdata,
    output logic [STRB_W-1:0] s_wstrb,
    output logic              s_wen,
    input  logic              s_wready,
    output logic [ADDR_W-1:0] s_raddr,
    output logic              s_ren,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic              s_rvalid,
    output logic [1:0]        grant,
    output logic              timeout_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GNT0 = 2'd1;
    localparam logic [1:0] GNT1 = 2'd2;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("lb_arbiter: TIMEOUT_CYCLES must be >= 2");
    end

    logic [1:0]        state, state_nx;
    logic              last, last_nx;
    logic              req0, req1;
    logic              granted, hs, done, tmo_hit;
    logic              sel_wen, sel_ren;
    logic [ADDR_W-1:0] sel_waddr, sel_raddr;
    logic [DATA_W-1:0] sel_wdata, rd_data;
    logic [STRB_W-1:0] sel_wstrb;
    logic              wr_done, rd_done;

    assign req0    = m0_wen | m0_ren;
    assign req1    = m1_wen | m1_ren;
    assign grant   = {state == GNT1, state == GNT0};
    assign granted = grant[0] | grant[1];

    assign sel_wen   = grant[1] ? m1_wen   : m0_wen;
    assign sel_ren   = grant[1] ? m1_ren   : m0_ren;
    assign sel_waddr = grant[1] ? m1_waddr : m0_waddr;
    assign sel_wdata = grant[1] ? m1_wdata : m0_wdata;
    assign sel_wstrb = grant[1] ? m1_wstrb : m0_wstrb;
    assign sel_raddr = grant[1] ? m1_raddr : m0_raddr;

    // Write wins when the granted master raises both; the read is re-arbitrated later.
    always_comb begin
        s_wen   = 1'b0;
        s_ren   = 1'b0;
        s_waddr = '0;
        s_wdata = '0;
        s_wstrb = '0;
        s_raddr = '0;
        if (granted) begin
            s_wen   = sel_wen;
            s_ren   = ~sel_wen & sel_ren;
            s_waddr = sel_waddr;
            s_wdata = sel_wdata;
            s_wstrb = sel_wstrb;
            s_raddr = sel_raddr;
        end
    end

    assign hs = (s_wen & s_wready) | (s_ren & s_rvalid);

`ifdef LB_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] tmo_cnt;
    logic             tmo_err;

    assign tmo_hit = granted & ~hs & (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
            tmo_err <= 1'b0;
        end else begin
            if (!granted || hs || tmo_hit)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_hit)
                tmo_err <= 1'b1;
        end
    end

    assign timeout_err = tmo_err;
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign done    = hs | tmo_hit;
    // A forced completion returns zero read data since the slave never drove any.
    assign wr_done = s_wen & (s_wready | tmo_hit);
    assign rd_done = s_ren & (s_rvalid | tmo_hit);
    assign rd_data = (s_ren & s_rvalid) ? s_rdata : '0;

    assign m0_wready = grant[0] & wr_done;
    assign m0_rvalid = grant[0] & rd_done;
    assign m0_rdata  = grant[0] ? rd_data : '0;
    assign m1_wready = grant[1] & wr_done;
    assign m1_rvalid = grant[1] & rd_done;
    assign m1_rdata  = grant[1] ? rd_data : '0;

    // Round-robin pointer only moves on contested grants.
    always_comb begin
        state_nx = state;
        last_nx  = last;
        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    if (last) begin
                        state_nx = GNT0;
                        last_nx  = 1'b0;
                    end else begin
                        state_nx = GNT1;
                        last_nx  = 1'b1;
                    end
                end else if (req0) begin
                    state_nx = GNT0;
                end else if (req1) begin
                    state_nx = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (done)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nx;
            last  <= last_nx;
        end
    end

endmodule

// File: tb/tb_lb_arbiter.sv
// Scoreboard bench for lb_arbiter: expected slave handshakes are queued at stimulus time
// and checked when the slave model completes them.
module tb_lb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  waddr [2];
    logic [7:0]  raddr [2];
    logic [15:0] wdata [2];
    logic [1:0]  wstrb [2];
    logic [1:0]  wen, ren;
    logic        mwready [2];
    logic        mrvalid [2];
    logic [15:0] mrdata  [2];
    logic [7:0]  s_waddr, s_raddr;
    logic [15:0] s_wdata, s_rdata;
    logic [1:0]  s_wstrb, grant;
    logic        s_wen, s_ren, s_wready, s_rvalid, timeout_err;

    int vectors = 0;
    int miscompares = 0;
    int wdelay, rdelay, slv_cnt;
    logic stray;
    int gcyc0 = 0, gact0 = 0, wpulse0 = 0, wpulse1 = 0;
    int switch_err = 0, both_err = 0;
    logic [1:0] prev_grant = 2'b00;

    typedef struct packed {
        logic [1:0]  g;
        logic        wr;
        logic [7:0]  a;
        logic [15:0] d;
        logic [1:0]  s;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    lb_arbiter #(.ADDR_W(8), .DATA_W(16), .STRB_W(2), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .m0_waddr(waddr[0]), .m0_wdata(wdata[0]), .m0_wstrb(wstrb[0]), .m0_wen(wen[0]),
        .m0_wready(mwready[0]), .m0_raddr(raddr[0]), .m0_ren(ren[0]),
        .m0_rdata(mrdata[0]), .m0_rvalid(mrvalid[0]),
        .m1_waddr(waddr[1]), .m1_wdata(wdata[1]), .m1_wstrb(wstrb[1]), .m1_wen(wen[1]),
        .m1_wready(mwready[1]), .m1_raddr(raddr[1]), .m1_ren(ren[1]),
        .m1_rdata(mrdata[1]), .m1_rvalid(mrvalid[1]),
        .s_waddr(s_waddr), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wen(s_wen),
        .s_wready(s_wready), .s_raddr(s_raddr), .s_ren(s_ren),
        .s_rdata(s_rdata), .s_rvalid(s_rvalid),
        .grant(grant), .timeout_err(timeout_err)
    );

    function automatic logic [15:0] rd_model(input logic [7:0] a);
        case (a)
            8'h10:   return 16'h1111;
            8'h20:   return 16'h2222;
            8'h0C:   return 16'h0C0C;
            default: return {a, ~a};
        endcase
    endfunction

    // Slave model: responds after a programmable number of wait cycles.
    assign s_wready = s_wen && (slv_cnt >= wdelay);
    assign s_rvalid = (s_ren && (slv_cnt >= rdelay)) || stray;
    assign s_rdata  = s_rvalid ? rd_model(s_raddr) : 16'h0000;

    always @(posedge clk or posedge rst) begin
        if (rst)
            slv_cnt <= 0;
        else if ((s_wen && s_wready) || (s_ren && s_rvalid) || !(s_wen || s_ren))
            slv_cnt <= 0;
        else
            slv_cnt <= slv_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [1:0] g, input logic wr, input logic [7:0] a,
                        input logic [15:0] d, input logic [1:0] s);
        exp_t e;
        e.g = g; e.wr = wr; e.a = a; e.d = d; e.s = s;
        sb.push_back(e);
    endtask

    // Monitor: scoreboard pops on every slave handshake, plus grant sanity counters.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (grant != 2'b00 && prev_grant != 2'b00 && grant != prev_grant)
                switch_err <= switch_err + 1;
            if (grant == 2'b11)
                both_err <= both_err + 1;
            prev_grant <= grant;
            if (grant == 2'b01 && s_wen) gcyc0 <= gcyc0 + 1;
            if (grant == 2'b01) gact0 <= gact0 + 1;
            if (mwready[0]) wpulse0 <= wpulse0 + 1;
            if (mwready[1]) wpulse1 <= wpulse1 + 1;
            if ((s_wen && s_wready) || (s_ren && s_rvalid)) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_grant", grant, e.g);
                    chk("sb_kind", s_wen, e.wr);
                    chk("sb_resp", {mwready[1], mrvalid[1], mwready[0], mrvalid[0]},
                        {e.g[1] & e.wr, e.g[1] & ~e.wr, e.g[0] & e.wr, e.g[0] & ~e.wr});
                    chk("sb_other_rdata", e.g[1] ? mrdata[0] : mrdata[1], 0);
                    if (e.wr) begin
                        chk("sb_waddr", s_waddr, e.a);
                        chk("sb_wdata", s_wdata, e.d);
                        chk("sb_wstrb", s_wstrb, e.s);
                    end else begin
                        chk("sb_raddr", s_raddr, e.a);
                        chk("sb_rdata", e.g[1] ? mrdata[1] : mrdata[0], e.d);
                    end
                end
            end
        end
    end

    // One master transaction; each request is dropped just after the edge that completes it.
    task automatic xfer(input int m, input logic dw, input logic dr,
                        input logic [7:0] wa, input logic [15:0] wd, input logic [1:0] ws,
                        input logic [7:0] ra, input logic [15:0] exp_rd);
        int n;
        logic gw, gr;
        waddr[m] = wa; wdata[m] = wd; wstrb[m] = ws; raddr[m] = ra;
        wen[m] = dw; ren[m] = dr;
        n = 0;
        while ((wen[m] || ren[m]) && n < 300) begin
            @(negedge clk);
            n++;
            gw = wen[m] && mwready[m];
            gr = ren[m] && mrvalid[m];
            if (gr) chk($sformatf("m%0d_rdata", m), mrdata[m], exp_rd);
            @(posedge clk);
            #1;
            if (gw) wen[m] = 1'b0;
            if (gr) ren[m] = 1'b0;
        end
        chk($sformatf("m%0d_xfer_done", m), {wen[m], ren[m]}, 0);
        wen[m] = 1'b0;
        ren[m] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w0, w1, g0;
        rst = 1'b1; wen = '0; ren = '0; stray = 1'b0; wdelay = 0; rdelay = 0;
        for (int i = 0; i < 2; i++) begin
            waddr[i] = '0; raddr[i] = '0; wdata[i] = '0; wstrb[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_s_ctl", {s_wen, s_ren}, 0);
        chk("rst_s_bus", {s_waddr, s_wdata, s_wstrb, s_raddr}, 0);
        chk("rst_m_resp", {mwready[0], mrvalid[0], mwready[1], mrvalid[1]}, 0);
        chk("rst_m_rdata", {mrdata[1], mrdata[0]}, 0);
        chk("rst_tmo_err", timeout_err, 0);
        rst = 1'b0;

        // Unsolicited slave rvalid while idle must not reach any master.
        @(negedge clk);
        stray = 1'b1;
        #1;
        chk("stray_rvalid", {mrvalid[1], mrvalid[0]}, 0);
        chk("stray_rdata", {mrdata[1], mrdata[0]}, 0);
        stray = 1'b0;
        @(posedge clk);
        #1;

        // m0 write alone, zero-wait slave
        w0 = wpulse0; w1 = wpulse1;
        push(2'b01, 1'b1, 8'h04, 16'hA5A5, 2'b11);
        fork
            xfer(0, 1'b1, 1'b0, 8'h04, 16'hA5A5, 2'b11, 8'h00, 16'h0000);
            begin
                @(negedge clk);
                chk("t1_pre_grant", grant, 2'b00);
                chk("t1_pre_swen", s_wen, 0);
                @(negedge clk);
                chk("t1_grant", grant, 2'b01);
                chk("t1_swen", {s_wen, s_ren}, 2'b10);
                chk("t1_sbus", {s_waddr, s_wdata, s_wstrb}, {8'h04, 16'hA5A5, 2'b11});
                chk("t1_m1_wready", mwready[1], 0);
                @(negedge clk);
                chk("t1_post_grant", grant, 2'b00);
                chk("t1_post_swen", s_wen, 0);
            end
        join
        @(posedge clk);
        #1;
        chk("t1_m0_pulses", wpulse0 - w0, 1);
        chk("t1_m1_pulses", wpulse1 - w1, 0);

        // Simultaneous reads: m0 first after reset, then m1 first on the next tie
        push(2'b01, 1'b0, 8'h10, 16'h1111, 2'b00);
        push(2'b10, 1'b0, 8'h20, 16'h2222, 2'b00);
        fork
            xfer(0, 1'b0, 1'b1, 8'h00, 16'h0000, 2'b00, 8'h10, 16'h1111);
            xfer(1, 1'b0, 1'b1, 8'h00, 16'h0000, 2'b00, 8'h20, 16'h2222);
        join
        push(2'b10, 1'b0, 8'h20, 16'h2222, 2'b00);
        push(2'b01, 1'b0, 8'h10, 16'h1111, 2'b00);
        fork
            xfer(0, 1'b0, 1'b1, 8'h00, 16'h0000, 2'b00, 8'h10, 16'h1111);
            xfer(1, 1'b0, 1'b1, 8'h00, 16'h0000, 2'b00, 8'h20, 16'h2222);
        join

        // m1 write+read, m0 read one cycle later: m1 write, m0 read, m1 read
        push(2'b10, 1'b1, 8'h08, 16'hBEEF, 2'b01);
        push(2'b01, 1'b0, 8'h10, 16'h1111, 2'b00);
        push(2'b10, 1'b0, 8'h0C, 16'h0C0C, 2'b00);
        fork
            xfer(1, 1'b1, 1'b1, 8'h08, 16'hBEEF, 2'b01, 8'h0C, 16'h0C0C);
            begin
                @(posedge clk);
                #1;
                xfer(0, 1'b0, 1'b1, 8'h00, 16'h0000, 2'b00, 8'h10, 16'h1111);
            end
        join

        // Slave stalls the write for 5 cycles; m1 arrives mid-grant
        wdelay = 5;
        g0 = gcyc0;
        push(2'b01, 1'b1, 8'h30, 16'h1234, 2'b11);
        push(2'b10, 1'b0, 8'h20, 16'h2222, 2'b00);
        fork
            xfer(0, 1'b1, 1'b0, 8'h30, 16'h1234, 2'b11, 8'h00, 16'h0000);
            begin
                repeat (2) @(posedge clk);
                #1;
                xfer(1, 1'b0, 1'b1, 8'h00, 16'h0000, 2'b00, 8'h20, 16'h2222);
            end
        join
        chk("t4_hold_cycles", gcyc0 - g0, 6);
        wdelay = 0;

        // Reset during a granted read; the held request is served after release
        rdelay = 10;
        push(2'b01, 1'b0, 8'h10, 16'h1111, 2'b00);
        fork
            xfer(0, 1'b0, 1'b1, 8'h00, 16'h0000, 2'b00, 8'h10, 16'h1111);
            begin
                @(posedge clk);
                #3;
                chk("t5_pre_grant", {grant, s_ren}, 3'b011);
                rst = 1'b1;
                #1;
                chk("t5_async_grant", grant, 0);
                chk("t5_async_sren", {s_ren, s_wen}, 0);
                @(posedge clk);
                #1;
                rst = 1'b0;
                rdelay = 0;
            end
        join

`ifdef LB_ARB_TIMEOUT_EN
        rdelay = 1000;
        g0 = gact0;
        xfer(0, 1'b0, 1'b1, 8'h00, 16'h0000, 2'b00, 8'h40, 16'h0000);
        @(posedge clk);
        #1;
        chk("t6_granted_cycles", gact0 - g0, 8);
        chk("t6_tmo_err", timeout_err, 1);
        rdelay = 0;
        push(2'b10, 1'b1, 8'h44, 16'hCAFE, 2'b11);
        xfer(1, 1'b1, 1'b0, 8'h44, 16'hCAFE, 2'b11, 8'h00, 16'h0000);
        chk("t6_tmo_sticky", timeout_err, 1);
`else
        chk("tmo_err_tied", timeout_err, 0);
`endif

        @(posedge clk);
        #1;
        chk("no_direct_switch", switch_err, 0);
        chk("no_double_grant", both_err, 0);
        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
